// File: rtl/trap_pkg.sv
// trap_pkg: shared types and constants for the machine-mode trap controller.
//   pc_src_e  - next-PC selector encoding driven toward the PC mux
//   state_e   - trap FSM states
//   CSR_*     - CSR addresses decoded by trap_ctrl
//   CAUSE_*   - exception / interrupt cause codes
package trap_pkg;

  typedef enum logic [1:0] {
    PC_RESET = 2'b00,
    PC_TRAP  = 2'b01,
    PC_EPC   = 2'b10,
    PC_NEXT  = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    S_RST  = 2'b00,
    S_RUN  = 2'b01,
    S_TRAP = 2'b10,
    S_RET  = 2'b11
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_ECALL     = 4'd11;
  localparam logic [3:0] CAUSE_SW_IRQ    = 4'd3;
  localparam logic [3:0] CAUSE_TIMER_IRQ = 4'd7;
  localparam logic [3:0] CAUSE_EXT_IRQ   = 4'd11;

  // Bit positions shared by mie and mip.
  localparam int IRQ_BIT_SW    = 3;
  localparam int IRQ_BIT_TIMER = 7;
  localparam int IRQ_BIT_EXT   = 11;

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: pipeline <-> trap controller signal bundle.
//   master modport: pipeline side (drives IRQs, exceptions, mret, stall, CSR
//                   write port; receives csr_rdata, pc_src, pc_trap, mepc, flush)
//   slave modport:  trap_ctrl side (the reverse)
interface trap_ctrl_if;
  import trap_pkg::*;

  logic        ext_irq;
  logic        sw_irq;
  logic        timer_irq;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] resume_pc;
  logic        mret;
  logic        hazard_full;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  pc_src_e     pc_src;
  logic [31:0] pc_trap;
  logic [31:0] mepc;
  logic        flush;

  modport master (
    output ext_irq, sw_irq, timer_irq, exc_valid, exc_cause, exc_pc,
           resume_pc, mret, hazard_full, csr_we, csr_addr, csr_wdata,
    input  csr_rdata, pc_src, pc_trap, mepc, flush
  );

  modport slave (
    input  ext_irq, sw_irq, timer_irq, exc_valid, exc_cause, exc_pc,
           resume_pc, mret, hazard_full, csr_we, csr_addr, csr_wdata,
    output csr_rdata, pc_src, pc_trap, mepc, flush
  );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: combinational fixed-priority pick among the enabled, pending
// machine interrupts.
//   i_pend_ext/sw/timer : mip & mie per source
//   i_gie               : mstatus.MIE
//   o_valid             : an interrupt should be taken
//   o_cause             : cause code of the winner (ext > sw > timer)
module irq_arbiter
  import trap_pkg::*;
(
  input  logic       i_pend_ext,
  input  logic       i_pend_sw,
  input  logic       i_pend_timer,
  input  logic       i_gie,
  output logic       o_valid,
  output logic [3:0] o_cause
);

  always_comb begin
    o_valid = i_gie && (i_pend_ext || i_pend_sw || i_pend_timer);
    o_cause = 4'd0;
    if (i_pend_ext)
      o_cause = CAUSE_EXT_IRQ;
    else if (i_pend_sw)
      o_cause = CAUSE_SW_IRQ;
    else if (i_pend_timer)
      o_cause = CAUSE_TIMER_IRQ;
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap and interrupt controller.
// Owns mstatus (MIE/MPIE), mie, mip, mtvec, mepc, mcause; arbitrates
// exception > interrupt > mret while running and unstalled, and drives the
// control side of the next-PC mux.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : trap_ctrl_if.slave (IRQs, exception, mret, stall, CSR port,
//           pc_src / pc_trap / mepc / flush outputs)
// Parameter MTVEC_RST: reset value of mtvec.
// Build option TRAP_VECTORED_EN: when defined, mtvec[1:0] is writable and
// mode 01 vectors interrupts to base + 4*cause; otherwise mtvec[1:0] reads 0
// and every trap goes to base.
module trap_ctrl #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  trap_ctrl_if.slave  bus
);
  import trap_pkg::*;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  state_e      state_reg;
  pc_src_e     pc_src_reg;
  logic        flush_reg;
  logic        mstatus_mie_reg;
  logic        mstatus_mpie_reg;
  logic [31:0] mie_reg;
  logic [31:0] mip_reg;
  logic [31:0] mtvec_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] pc_trap_reg;

  logic        irq_valid;
  logic [3:0]  irq_cause;
  logic        run_ok;
  logic        take_exc;
  logic        take_irq;
  logic        take_trap;
  logic        take_ret;
  logic        csr_wr_ok;
  logic [31:0] trap_base;
  logic [31:0] trap_target;
  logic [3:0]  trap_cause;

  irq_arbiter u_irq_arbiter (
    .i_pend_ext   (mip_reg[IRQ_BIT_EXT]   & mie_reg[IRQ_BIT_EXT]),
    .i_pend_sw    (mip_reg[IRQ_BIT_SW]    & mie_reg[IRQ_BIT_SW]),
    .i_pend_timer (mip_reg[IRQ_BIT_TIMER] & mie_reg[IRQ_BIT_TIMER]),
    .i_gie        (mstatus_mie_reg),
    .o_valid      (irq_valid),
    .o_cause      (irq_cause)
  );

  // Events are only looked at while running and unstalled; a stall merely
  // defers them because exceptions are held upstream and IRQs are levels.
  assign run_ok    = (state_reg == S_RUN) && !bus.hazard_full;
  assign take_exc  = run_ok && bus.exc_valid;
  assign take_irq  = run_ok && !bus.exc_valid && irq_valid;
  assign take_trap = take_exc || take_irq;
  assign take_ret  = run_ok && !bus.exc_valid && !irq_valid && bus.mret;
  assign trap_cause = take_exc ? bus.exc_cause : irq_cause;

  // While flushing (S_TRAP/S_RET) the writing instruction is being killed.
  assign csr_wr_ok = bus.csr_we && (state_reg == S_RUN || state_reg == S_RST);

  assign trap_base = {mtvec_reg[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign trap_target = (take_irq && mtvec_reg[1:0] == 2'b01)
                     ? trap_base + {26'd0, irq_cause, 2'b00}
                     : trap_base;
`else
  assign trap_target = trap_base;
`endif

  // FSM with registered pc_src/flush so the outputs are glitch-free and
  // line up with the state they describe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= S_RST;
      pc_src_reg <= PC_RESET;
      flush_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_RST: begin
          state_reg  <= S_RUN;
          pc_src_reg <= PC_NEXT;
          flush_reg  <= 1'b0;
        end
        S_RUN: begin
          if (take_trap) begin
            state_reg  <= S_TRAP;
            pc_src_reg <= PC_TRAP;
            flush_reg  <= 1'b1;
          end else if (take_ret) begin
            state_reg  <= S_RET;
            pc_src_reg <= PC_EPC;
            flush_reg  <= 1'b1;
          end else begin
            state_reg  <= S_RUN;
            pc_src_reg <= PC_NEXT;
            flush_reg  <= 1'b0;
          end
        end
        S_TRAP, S_RET: begin
          state_reg  <= S_RUN;
          pc_src_reg <= PC_NEXT;
          flush_reg  <= 1'b0;
        end
        default: begin
          state_reg  <= S_RST;
          pc_src_reg <= PC_RESET;
          flush_reg  <= 1'b0;
        end
      endcase
    end
  end

  // CSR file. Software writes come first; the trap/mret updates below are
  // later in the block so they override mstatus/mepc/mcause on a collision.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= 32'd0;
      mip_reg          <= 32'd0;
      mtvec_reg        <= MTVEC_RST;
      mepc_reg         <= 32'd0;
      mcause_reg       <= 32'd0;
      pc_trap_reg      <= 32'd0;
    end else begin
      mip_reg <= {20'd0, bus.ext_irq, 3'd0, bus.timer_irq, 3'd0,
                  bus.sw_irq, 3'd0};

      if (csr_wr_ok) begin
        case (bus.csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_reg  <= bus.csr_wdata[3];
            mstatus_mpie_reg <= bus.csr_wdata[7];
          end
          CSR_MIE:    mie_reg    <= bus.csr_wdata & MIE_MASK;
`ifdef TRAP_VECTORED_EN
          CSR_MTVEC:  mtvec_reg  <= bus.csr_wdata;
`else
          CSR_MTVEC:  mtvec_reg  <= {bus.csr_wdata[31:2], 2'b00};
`endif
          CSR_MEPC:   mepc_reg   <= {bus.csr_wdata[31:2], 2'b00};
          CSR_MCAUSE: mcause_reg <= bus.csr_wdata;
          default: ;
        endcase
      end

      if (take_trap) begin
        mepc_reg         <= take_exc ? {bus.exc_pc[31:2], 2'b00}
                                     : {bus.resume_pc[31:2], 2'b00};
        mcause_reg       <= {take_irq, 27'd0, trap_cause};
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
        pc_trap_reg      <= trap_target;
      end else if (take_ret) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.csr_rdata = 32'd0;
    case (bus.csr_addr)
      CSR_MSTATUS: bus.csr_rdata = {24'd0, mstatus_mpie_reg, 3'd0,
                                    mstatus_mie_reg, 3'd0};
      CSR_MIE:     bus.csr_rdata = mie_reg;
      CSR_MTVEC:   bus.csr_rdata = mtvec_reg;
      CSR_MEPC:    bus.csr_rdata = mepc_reg;
      CSR_MCAUSE:  bus.csr_rdata = mcause_reg;
      CSR_MIP:     bus.csr_rdata = mip_reg;
      default:     bus.csr_rdata = 32'd0;
    endcase
  end

  assign bus.pc_src  = pc_src_reg;
  assign bus.flush   = flush_reg;
  assign bus.pc_trap = pc_trap_reg;
  assign bus.mepc    = mepc_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_trap_ctrl;
  import trap_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [31:0] rd;
  logic [31:0] exp_vec;

  trap_ctrl_if bus ();

  trap_ctrl #(.MTVEC_RST(32'h0000_0100)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = addr;
    bus.csr_wdata = data;
    tick();
    bus.csr_we    = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
    bus.csr_addr = addr;
    #1;
    data = bus.csr_rdata;
  endtask

  function automatic logic [31:0] src(input pc_src_e s);
    return {30'd0, s};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.ext_irq = 0; bus.sw_irq = 0; bus.timer_irq = 0;
    bus.exc_valid = 0; bus.exc_cause = 0; bus.exc_pc = 0; bus.resume_pc = 0;
    bus.mret = 0; bus.hazard_full = 0;
    bus.csr_we = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
    tick();
    tick();

    // Reset state and release
    check_eq("rst_pc_src", src(bus.pc_src), 32'h0);
    check_eq("rst_flush", {31'd0, bus.flush}, 32'h0);
    check_eq("rst_pc_trap", bus.pc_trap, 32'h0);
    check_eq("rst_mepc", bus.mepc, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("rel_pc_src_00", src(bus.pc_src), 32'h0);
    tick();
    check_eq("run_pc_src_11", src(bus.pc_src), 32'h3);
    csr_read(CSR_MTVEC, rd);   check_eq("mtvec_rst", rd, 32'h100);
    csr_read(CSR_MSTATUS, rd); check_eq("mstatus_rst", rd, 32'h0);

    // Timer interrupt, direct mode
    csr_write(CSR_MIE, 32'h80);
    csr_write(CSR_MSTATUS, 32'h8);
    csr_read(CSR_MSTATUS, rd); check_eq("mstatus_wr", rd, 32'h8);
    bus.resume_pc = 32'h40;
    bus.timer_irq = 1'b1;
    tick();
    check_eq("tmr_no_trap_yet", src(bus.pc_src), 32'h3);
    bus.timer_irq = 1'b0;
    tick();
    check_eq("tmr_pc_src", src(bus.pc_src), 32'h1);
    check_eq("tmr_flush", {31'd0, bus.flush}, 32'h1);
    check_eq("tmr_pc_trap", bus.pc_trap, 32'h100);
    check_eq("tmr_mepc", bus.mepc, 32'h40);
    csr_read(CSR_MCAUSE, rd);  check_eq("tmr_mcause", rd, 32'h8000_0007);
    csr_read(CSR_MSTATUS, rd); check_eq("tmr_mstatus", rd, 32'h80);
    tick();
    check_eq("tmr_back_run", src(bus.pc_src), 32'h3);
    check_eq("tmr_flush_off", {31'd0, bus.flush}, 32'h0);

    // mret
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    check_eq("ret_pc_src", src(bus.pc_src), 32'h2);
    check_eq("ret_flush", {31'd0, bus.flush}, 32'h1);
    check_eq("ret_mepc", bus.mepc, 32'h40);
    csr_read(CSR_MSTATUS, rd); check_eq("ret_mstatus", rd, 32'h88);
    tick();
    check_eq("ret_back_run", src(bus.pc_src), 32'h3);

    // ext + timer together, possibly vectored
    csr_write(CSR_MTVEC, 32'h201);
`ifdef TRAP_VECTORED_EN
    csr_read(CSR_MTVEC, rd); check_eq("mtvec_wr", rd, 32'h201);
    exp_vec = 32'h22C;
`else
    csr_read(CSR_MTVEC, rd); check_eq("mtvec_wr", rd, 32'h200);
    exp_vec = 32'h200;
`endif
    csr_write(CSR_MIE, 32'h880);
    bus.resume_pc = 32'h60;
    bus.ext_irq = 1'b1;
    bus.timer_irq = 1'b1;
    tick();
    tick();
    check_eq("ext_pc_src", src(bus.pc_src), 32'h1);
    csr_read(CSR_MCAUSE, rd); check_eq("ext_mcause", rd, 32'h8000_000B);
    check_eq("ext_pc_trap", bus.pc_trap, exp_vec);
    check_eq("ext_mepc", bus.mepc, 32'h60);
    bus.ext_irq = 1'b0;
    bus.timer_irq = 1'b0;
    tick();

    // Exception beats a pending interrupt
    csr_write(CSR_MSTATUS, 32'h8);
    bus.timer_irq = 1'b1;
    tick();
    bus.exc_valid = 1'b1;
    bus.exc_cause = CAUSE_ILLEGAL;
    bus.exc_pc = 32'h80;
    tick();
    bus.exc_valid = 1'b0;
    check_eq("exc_pc_src", src(bus.pc_src), 32'h1);
    csr_read(CSR_MCAUSE, rd); check_eq("exc_mcause", rd, 32'h2);
    check_eq("exc_mepc", bus.mepc, 32'h80);
    check_eq("exc_pc_trap", bus.pc_trap, 32'h200);
    tick();
    bus.timer_irq = 1'b0;
    tick();

    // Stall defers the interrupt
    csr_write(CSR_MSTATUS, 32'h8);
    bus.hazard_full = 1'b1;
    bus.resume_pc = 32'h90;
    bus.timer_irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_%0d_pc_src", i), src(bus.pc_src), 32'h3);
    end
    bus.hazard_full = 1'b0;
    tick();
    check_eq("stall_clear_pc_src", src(bus.pc_src), 32'h1);
    check_eq("stall_mepc", bus.mepc, 32'h90);

    // Reset while in S_TRAP
    rst = 1'b1;
    #1;
    check_eq("midrst_pc_src", src(bus.pc_src), 32'h0);
    check_eq("midrst_flush", {31'd0, bus.flush}, 32'h0);
    check_eq("midrst_pc_trap", bus.pc_trap, 32'h0);
    check_eq("midrst_mepc", bus.mepc, 32'h0);
    csr_read(CSR_MTVEC, rd); check_eq("midrst_mtvec", rd, 32'h100);
    bus.timer_irq = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("rerun_pc_src", src(bus.pc_src), 32'h3);

    // CSR boundary behaviour
    csr_write(CSR_MIP, 32'hFFFF_FFFF);
    csr_read(CSR_MIP, rd); check_eq("mip_ro", rd, 32'h0);
    csr_write(CSR_MEPC, 32'h123);
    csr_read(CSR_MEPC, rd); check_eq("mepc_align", rd, 32'h120);
    bus.csr_we = 1'b1;
    bus.csr_addr = CSR_MEPC;
    bus.csr_wdata = 32'h456;
    #1;
    check_eq("mepc_old_in_wr", bus.csr_rdata, 32'h120);
    tick();
    bus.csr_we = 1'b0;
    csr_read(CSR_MEPC, rd); check_eq("mepc_new", rd, 32'h454);
    csr_write(CSR_MSTATUS, 32'hFFFF_FFFF);
    csr_read(CSR_MSTATUS, rd); check_eq("mstatus_mask", rd, 32'h88);
    csr_read(12'h7C0, rd); check_eq("unmapped", rd, 32'h0);

    // sw beats timer
    csr_write(CSR_MIE, 32'hFFFF_FFFF);
    csr_read(CSR_MIE, rd); check_eq("mie_mask", rd, 32'h888);
    bus.sw_irq = 1'b1;
    bus.timer_irq = 1'b1;
    tick();
    tick();
    check_eq("sw_pc_src", src(bus.pc_src), 32'h1);
    csr_read(CSR_MCAUSE, rd); check_eq("sw_mcause", rd, 32'h8000_0003);
    check_eq("sw_pc_trap", bus.pc_trap, 32'h100);
    bus.sw_irq = 1'b0;
    bus.timer_irq = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap and interrupt controller that drives the next-PC selector's control side. It owns `mstatus`/`mie`/`mip`/`mtvec`/`mepc`/`mcause` and arbitrates exceptions, the three machine interrupt sources and `mret`. It emits `pc_src`, `pc_trap`, `mepc` and `flush` toward the PC-next mux and the pipeline. It sits beside the execute stage.

## Interface
Parameters:
- `MTVEC_RST`, `32'h0000_0100`: reset value of `mtvec`.

Ports:
- `i_clk  in  1`: single clock, rising edge.
- `i_rst  in  1`: reset, asynchronous, active-high.
- `ext_irq`, `sw_irq`, `timer_irq  in  1 each`: level interrupt requests.
- `exc_valid  in  1`: execute-stage exception. Held by upstream while `hazard_full` is 1.
- `exc_cause  in  4`: exception code (2 = illegal, 11 = ecall).
- `exc_pc  in  32`: PC of the faulting instruction.
- `resume_pc  in  32`: PC of the oldest not-yet-retired instruction; becomes `mepc` on an interrupt.
- `mret  in  1`: `mret` in execute.
- `hazard_full  in  1`: pipeline stall.
- `csr_we  in  1`, `csr_addr  in  12`, `csr_wdata  in  32`: CSR write port.
- `csr_rdata  out  32`: combinational read of the CSR at `csr_addr`; 0 for unmapped addresses.
- `pc_src  out  2`: 00 RESET, 01 TRAP, 10 EPC, 11 NEXT.
- `pc_trap  out  32`: trap target, registered.
- `mepc  out  32`: `mepc` CSR value.
- `flush  out  1`: kill IF..EX contents.

## Operation
- Reset values:
  - `mstatus`, `mie`, `mip`, `mepc`, `mcause`, `pc_trap` = 0; `mtvec` = `MTVEC_RST`.
  - FSM = S_RST, so `pc_src` = 00 and `flush` = 0.
- CSR map: `mstatus` 0x300 (MIE bit 3, MPIE bit 7, all other bits read 0), `mie` 0x304 (bits 3/7/11), `mtvec` 0x305, `mepc` 0x341 (bits [1:0] forced to 0), `mcause` 0x342, `mip` 0x344 (read-only, writes ignored).
- `mip` bit 11 ← `ext_irq`, bit 3 ← `sw_irq`, bit 7 ← `timer_irq`; each is registered every cycle.
- An interrupt is taken when `mstatus.MIE` is set and `(mip & mie)` is nonzero. Priority: ext (cause 11) > sw (3) > timer (7).
- Arbitration priority: `exc_valid` > interrupt > `mret`. Events are only evaluated in S_RUN with `hazard_full` = 0.
- FSM states and transitions:
  - S_RST: → S_RUN on the next clock.
  - S_RUN: outputs `pc_src` = 11. Goes to S_TRAP on exception or interrupt, to S_RET on `mret`.
  - S_TRAP: outputs `pc_src` = 01 and `flush` = 1. Returns to S_RUN.
  - S_RET: outputs `pc_src` = 10 and `flush` = 1. Returns to S_RUN.
- Trap entry, at the edge leaving S_RUN:
  - `mepc` ← `exc_pc` for an exception, `resume_pc` for an interrupt.
  - `mcause` ← {interrupt flag in bit 31, zero-extended cause}.
  - `MPIE` ← `MIE`, `MIE` ← 0.
  - `pc_trap` ← target address.
- Trap target:
  - Base = {`mtvec[31:2]`, 2'b00}.
  - Vectored mode (see Configuration) with an interrupt: base + 4·cause, in 32-bit wrap-around arithmetic.
  - Otherwise: base.
- `mret`, at the edge leaving S_RUN: `MIE` ← `MPIE`, `MPIE` ← 1.
- A CSR write in the same cycle as trap entry or `mret`: the hardware update wins for `mstatus`/`mepc`/`mcause`. Writes to other CSRs proceed.
- In S_TRAP and S_RET, new events and CSR writes are ignored; the instructions are being flushed.

## Timing
- Event sampled at edge N (S_RUN, no stall) → `pc_src` = 01 or 10 during cycle N+1, for exactly one cycle. `pc_src` = 11 again at N+2.
- IRQ input rising → `mip` visible 1 cycle later → earliest trap-entry edge 2 cycles after the input rises.
- `hazard_full` = 1 defers evaluation. There are no lost events: exceptions are held upstream and IRQs are levels.
- `i_rst` asserted mid-trap → immediate return to reset values. `pc_src` = 00 until one clock after release.
- CSR writes take effect at the next edge; `csr_rdata` shows the old value in the write cycle.

## Configuration
- `TRAP_VECTORED_EN` defined: `mtvec[1:0]` is writable; mode 01 selects vectored interrupt targets.
- `TRAP_VECTORED_EN` undefined: `mtvec[1:0]` is hardwired to 00 (reads 0) and every trap goes to base.

## Structure
- Package `trap_pkg`:
  - `pc_src_e` enum (RESET/TRAP/EPC/NEXT = 00/01/10/11).
  - CSR address localparams.
  - Cause codes.
  - FSM state enum.
- One sub-module, `irq_arbiter`: combinational priority pick over `mip & mie` gated by MIE, returning valid plus a 4-bit cause.

## Test plan
- Reset release → `pc_src` = 00 for one cycle, then 11. `mtvec` reads 0x100.
- Set MIE and `mie[7]`, pulse `timer_irq` with `resume_pc` = 0x40 →
  - `pc_src` = 01 for one cycle, `pc_trap` = 0x100, `mepc` = 0x40, `mcause` = 0x8000_0007, MIE = 0, MPIE = 1.
- `mtvec` = 0x201 with `TRAP_VECTORED_EN` defined, then `ext_irq` and `timer_irq` together → `mcause` = 0x8000_000B, `pc_trap` = 0x22C.
- `exc_valid` (cause 2, `exc_pc` = 0x80) in the same cycle as a pending interrupt → exception wins: `mcause` = 2, `mepc` = 0x80, `pc_trap` = base.
- `mret` after a trap → `pc_src` = 10 for one cycle, `mepc` output unchanged, MIE restored to 1, MPIE = 1.
- Interrupt pending with `hazard_full` = 1 for 3 cycles → no trap during the stall; `pc_src` = 01 the cycle after the stall clears. `i_rst` during S_TRAP → all outputs reset.
